// File: rtl/dso_acq_ctrl_if.sv
// Capture-path bundle between ADC source, acquisition controller and waveform RAM.
// The controller takes the slave side; the source/reader side is master.
interface dso_acq_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        ad_data;
  logic              ad_valid;
  logic              wave_run;
  logic [7:0]        trig_level;
  logic              trig_edge;
  logic [9:0]        h_shift;
  logic [9:0]        deci_rate;
  logic              ram_rd_over;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [7:0]        ram_wr_data;
  logic              wave_ready;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] rd_start_addr;
  logic              trig_forced;

  modport master (
    output ad_data, ad_valid, wave_run, trig_level, trig_edge, h_shift, deci_rate, ram_rd_over,
    input  ram_wr_en, ram_wr_addr, ram_wr_data, wave_ready, trig_addr, rd_start_addr, trig_forced
  );

  modport slave (
    input  ad_data, ad_valid, wave_run, trig_level, trig_edge, h_shift, deci_rate, ram_rd_over,
    output ram_wr_en, ram_wr_addr, ram_wr_data, wave_ready, trig_addr, rd_start_addr, trig_forced
  );
endinterface

// File: rtl/dso_acq_ctrl.sv
// Decimating circular-buffer capture with pre-trigger depth, edge/auto trigger and frame hold.
// RAM write is registered one cycle after the kept sample; no backpressure, frame held until read-out.
module dso_acq_ctrl #(
  parameter int ADDR_W       = 10,
  parameter int AUTO_TIMEOUT = 0
) (
  input  logic          clk,
  input  logic          rst,
  dso_acq_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] h_lat_q, h_lat_d;
  logic [9:0]        deci_lat_q, deci_lat_d;
  logic [9:0]        deci_cnt_q, deci_cnt_d;
  logic [7:0]        level_q, level_d;
  logic              edge_q, edge_d;
  logic [7:0]        prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] rd_start_q, rd_start_d;
  logic              trig_forced_q, trig_forced_d;
  logic              wave_ready_q, wave_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_out_addr_q, wr_out_addr_d;
  logic [7:0]        wr_out_data_q, wr_out_data_d;

  logic        capturing, sample_in, keep, arm, real_trig, auto_trig;
  logic [31:0] cnt_inc, post_need;

  always_comb begin
    // A zero pre-trigger depth spends its single PRE cycle without capturing.
    capturing = bus.wave_run && (state_q inside {PRE, ARMED, POST}) &&
                !(state_q == PRE && h_lat_q == '0);
    sample_in = capturing && bus.ad_valid;
    keep      = sample_in && (deci_cnt_q == '0);
    cnt_inc   = cnt_q + 32'd1;
    post_need = 32'(DEPTH) - 32'(h_lat_q);
    real_trig = prev_vld_q && (edge_q ? (prev_q >= level_q && bus.ad_data < level_q)
                                      : (prev_q < level_q && bus.ad_data >= level_q));
    auto_trig = (AUTO_TIMEOUT != 0) && (cnt_inc == 32'(AUTO_TIMEOUT));
    arm       = bus.wave_run && (state_q == IDLE || (state_q == DONE && bus.ram_rd_over));
  end

  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    h_lat_d       = h_lat_q;
    deci_lat_d    = deci_lat_q;
    deci_cnt_d    = deci_cnt_q;
    level_d       = level_q;
    edge_d        = edge_q;
    prev_d        = prev_q;
    prev_vld_d    = prev_vld_q;
    cnt_d         = cnt_q;
    trig_addr_d   = trig_addr_q;
    rd_start_d    = rd_start_q;
    trig_forced_d = trig_forced_q;
    wave_ready_d  = 1'b0;
    wr_en_d       = 1'b0;
    wr_out_addr_d = wr_out_addr_q;
    wr_out_data_d = wr_out_data_q;

    if (sample_in) begin
      deci_cnt_d = (deci_cnt_q == deci_lat_q - 10'd1) ? '0 : deci_cnt_q + 10'd1;
    end
    if (keep) begin
      wr_en_d       = 1'b1;
      wr_out_addr_d = wr_addr_q;
      wr_out_data_d = bus.ad_data;
      wr_addr_d     = wr_addr_q + ADDR_W'(1);
      prev_d        = bus.ad_data;
      prev_vld_d    = 1'b1;
    end

    unique case (state_q)
      IDLE: ;
      PRE: begin
        if (!bus.wave_run) begin
          state_d = IDLE;
        end else if (h_lat_q == '0) begin
          state_d = ARMED;
        end else if (keep) begin
          if (cnt_inc == 32'(h_lat_q)) begin
            state_d = ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ARMED: begin
        if (!bus.wave_run) begin
          state_d = IDLE;
        end else if (keep) begin
          if (real_trig || auto_trig) begin
            trig_addr_d   = wr_addr_q;
            rd_start_d    = wr_addr_q - h_lat_q;
            trig_forced_d = !real_trig;
            cnt_d         = 32'd1;
            state_d       = (post_need == 32'd1) ? DONE : POST;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      POST: begin
        if (!bus.wave_run) begin
          state_d = IDLE;
        end else if (keep) begin
          cnt_d = cnt_inc;
          if (cnt_inc == post_need) state_d = DONE;
        end
      end
      DONE:    wave_ready_d = !arm;
      default: state_d = IDLE;
    endcase

    if (arm) begin
      state_d       = PRE;
      h_lat_d       = (32'(bus.h_shift) > 32'(DEPTH - 1)) ? ADDR_W'(DEPTH - 1) : ADDR_W'(bus.h_shift);
      deci_lat_d    = (bus.deci_rate == '0) ? 10'd1 : bus.deci_rate;
      level_d       = bus.trig_level;
      edge_d        = bus.trig_edge;
      wr_addr_d     = '0;
      deci_cnt_d    = '0;
      cnt_d         = '0;
      prev_vld_d    = 1'b0;
      trig_forced_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_addr_q     <= '0;
      h_lat_q       <= '0;
      deci_lat_q    <= '0;
      deci_cnt_q    <= '0;
      level_q       <= '0;
      edge_q        <= 1'b0;
      prev_q        <= '0;
      prev_vld_q    <= 1'b0;
      cnt_q         <= '0;
      trig_addr_q   <= '0;
      rd_start_q    <= '0;
      trig_forced_q <= 1'b0;
      wave_ready_q  <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_out_addr_q <= '0;
      wr_out_data_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      h_lat_q       <= h_lat_d;
      deci_lat_q    <= deci_lat_d;
      deci_cnt_q    <= deci_cnt_d;
      level_q       <= level_d;
      edge_q        <= edge_d;
      prev_q        <= prev_d;
      prev_vld_q    <= prev_vld_d;
      cnt_q         <= cnt_d;
      trig_addr_q   <= trig_addr_d;
      rd_start_q    <= rd_start_d;
      trig_forced_q <= trig_forced_d;
      wave_ready_q  <= wave_ready_d;
      wr_en_q       <= wr_en_d;
      wr_out_addr_q <= wr_out_addr_d;
      wr_out_data_q <= wr_out_data_d;
    end
  end

  assign bus.ram_wr_en     = wr_en_q;
  assign bus.ram_wr_addr   = wr_out_addr_q;
  assign bus.ram_wr_data   = wr_out_data_q;
  assign bus.wave_ready    = wave_ready_q;
  assign bus.trig_addr     = trig_addr_q;
  assign bus.rd_start_addr = rd_start_q;
  assign bus.trig_forced   = trig_forced_q;
endmodule

// File: tb/tb_dso_acq_ctrl.sv
// Bench for dso_acq_ctrl (ADDR_W=4, AUTO_TIMEOUT=32): directed and random captures
// compared against a list-based frame model of the acquisition rules.
module tb_dso_acq_ctrl;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int AUTO   = 32;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  dso_acq_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  dso_acq_ctrl #(.ADDR_W(ADDR_W), .AUTO_TIMEOUT(AUTO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  int got_addr[$];
  int got_data[$];
  int got_cyc[$];
  int rise_cyc[$];
  logic ready_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.ram_wr_en === 1'b1) begin
      got_addr.push_back(int'(bus.ram_wr_addr));
      got_data.push_back(int'(bus.ram_wr_data));
      got_cyc.push_back(cyc);
    end
    if (bus.wave_ready === 1'b1 && ready_prev !== 1'b1) rise_cyc.push_back(cyc);
    ready_prev <= bus.wave_ready;
  end

  int stim_d[$];
  bit stim_v[$];
  int exp_addr[$];
  int exp_data[$];
  int exp_idx[$];
  int exp_trig;
  int exp_start;
  bit exp_forced;
  bit exp_done;
  int s0;
  int base;
  int rbase;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Frame model: list of kept samples, first qualifying trigger, then slice the frame.
  task automatic model(input int deci, input int h, input int lvl, input bit edg);
    int kv[$];
    int ki[$];
    int dl, hl, nvalid, trig, n;
    bit hit;
    dl = (deci == 0) ? 1 : deci;
    hl = (h > DEPTH - 1) ? DEPTH - 1 : h;
    nvalid = 0;
    for (int i = (hl == 0) ? 1 : 0; i < stim_v.size(); i++) begin
      if (stim_v[i]) begin
        if (nvalid % dl == 0) begin
          kv.push_back(stim_d[i]);
          ki.push_back(i);
        end
        nvalid++;
      end
    end
    trig = -1;
    exp_forced = 1'b0;
    for (int k = hl; k < kv.size() && trig < 0; k++) begin
      hit = (k > 0) && (edg ? (kv[k-1] >= lvl && kv[k] < lvl) : (kv[k-1] < lvl && kv[k] >= lvl));
      if (hit || (k - hl + 1) == AUTO) begin
        trig = k;
        exp_forced = !hit;
      end
    end
    exp_done = (trig >= 0) && (trig + DEPTH - hl <= kv.size());
    n = exp_done ? trig + DEPTH - hl : kv.size();
    exp_addr.delete();
    exp_data.delete();
    exp_idx.delete();
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(i % DEPTH);
      exp_data.push_back(kv[i]);
      exp_idx.push_back(ki[i]);
    end
    exp_trig  = (trig < 0) ? 0 : trig % DEPTH;
    exp_start = ((trig - hl) % DEPTH + DEPTH) % DEPTH;
  endtask

  task automatic arm(input int deci, input int h, input int lvl, input bit edg);
    bit rearm;
    @(negedge clk);
    bus.deci_rate  = 10'(deci);
    bus.h_shift    = 10'(h);
    bus.trig_level = 8'(lvl);
    bus.trig_edge  = edg;
    rearm = (bus.wave_ready === 1'b1);
    if (rearm) begin
      bus.wave_run    = 1'b1;
      bus.ram_rd_over = 1'b1;
    end else begin
      bus.wave_run = 1'b0;
      @(negedge clk);
      bus.wave_run = 1'b1;
    end
    @(negedge clk);
    bus.ram_rd_over = 1'b0;
    if (rearm) chk("rearm_ready_low", 32'(bus.wave_ready), 32'd0);
  endtask

  // Latched parameters are scrambled after the first sample; the frame must not care.
  task automatic feed();
    s0    = cyc;
    base  = got_addr.size();
    rbase = rise_cyc.size();
    for (int i = 0; i < stim_v.size(); i++) begin
      bus.ad_valid = stim_v[i];
      bus.ad_data  = 8'(stim_d[i]);
      if (i == 1) begin
        bus.trig_level = 8'($urandom);
        bus.trig_edge  = 1'($urandom);
        bus.h_shift    = 10'($urandom_range(0, 20));
        bus.deci_rate  = 10'($urandom_range(0, 5));
      end
      @(negedge clk);
    end
    bus.ad_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    int n, last;
    n = got_addr.size() - base;
    chk({tag, "_nwr"}, 32'(n), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < n; i++) begin
      chk($sformatf("%s_wr%0d_addr", tag, i), 32'(got_addr[base+i]), 32'(exp_addr[i]));
      chk($sformatf("%s_wr%0d_data", tag, i), 32'(got_data[base+i]), 32'(exp_data[i]));
      chk($sformatf("%s_wr%0d_cyc", tag, i), 32'(got_cyc[base+i]), 32'(s0 + exp_idx[i] + 1));
    end
    chk({tag, "_ready"}, 32'(bus.wave_ready), 32'(exp_done));
    if (exp_done) begin
      last = (rise_cyc.size() > rbase) ? rise_cyc[rise_cyc.size()-1] : -1;
      chk({tag, "_ready_rise"}, 32'(last), 32'(s0 + exp_idx[exp_idx.size()-1] + 2));
      chk({tag, "_trig_addr"}, 32'(bus.trig_addr), 32'(exp_trig));
      chk({tag, "_rd_start"}, 32'(bus.rd_start_addr), 32'(exp_start));
      chk({tag, "_forced"}, 32'(bus.trig_forced), 32'(exp_forced));
    end
  endtask

  task automatic build(input int n, input int mode, input int p);
    stim_d.delete();
    stim_v.delete();
    for (int i = 0; i < n; i++) begin
      case (mode)
        0: stim_d.push_back((p + i) % 256);
        1: stim_d.push_back(p);
        2: stim_d.push_back((i < 20) ? 200 : 40);
        default: stim_d.push_back(int'($urandom_range(0, 255)));
      endcase
      stim_v.push_back((mode == 3) ? ($urandom_range(0, 9) < 7) : 1'b1);
    end
  endtask

  initial begin
    int deci, h, lvl;
    bit edg;
    bus.ad_data = '0; bus.ad_valid = 1'b0; bus.wave_run = 1'b0; bus.trig_level = '0;
    bus.trig_edge = 1'b0; bus.h_shift = '0; bus.deci_rate = '0; bus.ram_rd_over = 1'b0;
    rst = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("rst_wr_en", 32'(bus.ram_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.ram_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.ram_wr_data), 32'd0);
    chk("rst_ready", 32'(bus.wave_ready), 32'd0);
    chk("rst_trig_addr", 32'(bus.trig_addr), 32'd0);
    chk("rst_rd_start", 32'(bus.rd_start_addr), 32'd0);
    chk("rst_forced", 32'(bus.trig_forced), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Rising ramp through level 128 with 4 pre-trigger samples.
    arm(1, 4, 128, 1'b0);
    build(40, 0, 120);
    model(1, 4, 128, 1'b0);
    feed();
    repeat (3) @(negedge clk);
    check_frame("ramp");
    chk("ramp_trig_const", 32'(bus.trig_addr), 32'd8);
    chk("ramp_start_const", 32'(bus.rd_start_addr), 32'd4);

    // Frozen frame: read-out done with run low keeps the frame.
    bus.wave_run = 1'b0;
    bus.ram_rd_over = 1'b1;
    @(negedge clk);
    bus.ram_rd_over = 1'b0;
    repeat (2) @(negedge clk);
    chk("freeze_ready", 32'(bus.wave_ready), 32'd1);
    chk("freeze_nwr", 32'(got_addr.size() - base), 32'(exp_addr.size()));
    chk("freeze_trig", 32'(bus.trig_addr), 32'd8);

    arm(3, 5, 128, 1'b0);
    build(80, 0, 0);
    model(3, 5, 128, 1'b0);
    feed();
    repeat (3) @(negedge clk);
    check_frame("deci3");

    arm(0, 6, 64, 1'b1);
    build(40, 0, 90);
    model(0, 6, 64, 1'b1);
    feed();
    repeat (3) @(negedge clk);
    check_frame("deci0");

    arm(1, 20, 50, 1'b1);
    build(25, 2, 0);
    model(1, 20, 50, 1'b1);
    feed();
    repeat (3) @(negedge clk);
    check_frame("fall");
    chk("fall_nwr_const", 32'(got_addr.size() - base), 32'd21);
    chk("fall_forced_const", 32'(bus.trig_forced), 32'd0);

    arm(1, 4, 128, 1'b0);
    build(70, 1, 100);
    model(1, 4, 128, 1'b0);
    feed();
    repeat (3) @(negedge clk);
    check_frame("auto");
    chk("auto_forced_const", 32'(bus.trig_forced), 32'd1);

    // Abort while ARMED: further valids must not be written.
    arm(1, 4, 128, 1'b0);
    build(8, 1, 10);
    model(1, 4, 128, 1'b0);
    feed();
    bus.wave_run = 1'b0;
    bus.ad_valid = 1'b1;
    bus.ad_data  = 8'd10;
    repeat (5) @(negedge clk);
    bus.ad_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_frame("abort");

    for (int r = 0; r < 6; r++) begin
      deci = int'($urandom_range(0, 4));
      h    = int'($urandom_range(0, 20));
      lvl  = int'($urandom_range(0, 255));
      edg  = 1'($urandom);
      arm(deci, h, lvl, edg);
      build(450, 3, 0);
      model(deci, h, lvl, edg);
      feed();
      repeat (3) @(negedge clk);
      check_frame($sformatf("rand%0d", r));
    end

    // Reset in the middle of the post-trigger fill, then a clean recapture.
    arm(1, 4, 128, 1'b0);
    build(12, 0, 120);
    model(1, 4, 128, 1'b0);
    feed();
    chk("midpost_wr_en", 32'(bus.ram_wr_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_wr_en", 32'(bus.ram_wr_en), 32'd0);
    chk("midrst_wr_addr", 32'(bus.ram_wr_addr), 32'd0);
    chk("midrst_wr_data", 32'(bus.ram_wr_data), 32'd0);
    chk("midrst_trig_addr", 32'(bus.trig_addr), 32'd0);
    chk("midrst_rd_start", 32'(bus.rd_start_addr), 32'd0);
    chk("midrst_ready", 32'(bus.wave_ready), 32'd0);
    chk("midrst_forced", 32'(bus.trig_forced), 32'd0);
    bus.wave_run = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_frame("midrst_partial");

    arm(1, 4, 128, 1'b0);
    build(40, 0, 120);
    model(1, 4, 128, 1'b0);
    feed();
    repeat (3) @(negedge clk);
    check_frame("recap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dso_acq_ctrl.md
# dso_acq_ctrl

Acquisition controller for the oscilloscope capture path. Sits between the ADC sample stream and the waveform RAM write port. It decimates incoming samples and fills a circular buffer with a programmable pre-trigger depth, detects the trigger edge, and completes the post-trigger fill. It then holds the frame until the display reader signals read-out completion, and re-arms from there.

## Interface
- ADDR_W, 10, waveform RAM address width; DEPTH = 2**ADDR_W samples
- AUTO_TIMEOUT, 0, kept samples in ARMED before a forced trigger; 0 disables auto-trigger

Ports:
- clk  in  1  system clock; all logic single clock domain
- rst  in  1  asynchronous, active-high reset
- ad_data  in  8  ADC sample, synchronous to clk
- ad_valid  in  1  ad_data qualifier, one sample per high cycle
- wave_run  in  1  1 = acquire continuously, 0 = stop/freeze
- trig_level  in  8  trigger threshold, unsigned
- trig_edge  in  1  0 = rising, 1 = falling
- h_shift  in  10  pre-trigger sample count
- deci_rate  in  10  keep 1 of every deci_rate valid samples; 0 treated as 1
- ram_rd_over  in  1  one-cycle pulse from reader: frame read-out finished
- ram_wr_en  out  1  RAM write strobe
- ram_wr_addr  out  ADDR_W  RAM write address
- ram_wr_data  out  8  RAM write data
- wave_ready  out  1  complete frame in RAM, safe to read
- trig_addr  out  ADDR_W  RAM address of the trigger sample
- rd_start_addr  out  ADDR_W  first address of frame = (trig_addr - h_lat) mod DEPTH
- trig_forced  out  1  last frame was auto-triggered

## Operation
- Arm (entry to PRE) latches h_lat = min(h_shift, DEPTH-1), deci_lat = max(deci_rate,1), trig_level, trig_edge. Input changes mid-capture are ignored.
- Arm also clears the write address to 0, the decimation counter, the sample counters, prev_valid and trig_forced.
- Decimation: deci_cnt advances on each ad_valid and wraps at deci_lat-1. A sample is "kept" when ad_valid and deci_cnt==0, so the first valid sample after arming is always kept.
- Every kept sample in PRE/ARMED/POST is written at wr_addr. wr_addr then increments modulo DEPTH.
- Trigger compare uses each kept sample (cur) against prev, the previous kept sample of this arming. It requires prev_valid.
  - Rising trigger: prev < level and cur >= level.
  - Falling trigger: prev >= level and cur < level.
- States (encoding 0-4): IDLE, PRE, ARMED, POST, DONE.
  - IDLE: no writes. wave_run=1 -> arm, go PRE.
  - PRE: counts kept samples. After h_lat written -> ARMED. h_lat=0 goes to ARMED on the next cycle with no write. Triggers are ignored in PRE.
  - ARMED: a kept sample meeting the trigger condition is written. trig_addr takes its address, then -> POST with that sample counted as post sample 1.
    - If AUTO_TIMEOUT!=0 and the kept-sample count in ARMED reaches AUTO_TIMEOUT, that sample is forced as trigger and trig_forced=1.
    - A real trigger on the same sample wins, with trig_forced=0.
  - POST: after DEPTH-h_lat post samples (trigger included) are written -> DONE.
  - DONE: no writes; wave_ready=1.
    - ram_rd_over with wave_run=1 -> re-arm, go PRE, and wave_ready drops.
    - With wave_run=0, stay in DONE (frame frozen, reader may re-read).
- wave_run=0 in PRE/ARMED/POST aborts to IDLE and discards the partial frame. wave_ready stays 0.
- ram_rd_over outside DONE is ignored. ad_valid in IDLE/DONE is ignored.

## Timing
- Reset: state IDLE; all outputs 0; internal counters 0.
- ram_wr_en/addr/data are registered. Each is asserted for exactly one cycle, one cycle after the kept ad_valid cycle.
- trig_addr and the state change update on the same edge as the trigger sample's write strobe.
- wave_ready rises one cycle after the final POST ram_wr_en pulse. rd_start_addr and trig_addr are stable whenever wave_ready=1.
- wave_ready falls the cycle after the accepted ram_rd_over.
- Back-to-back ad_valid every cycle with deci_rate=1 gives one write per cycle, with no bubbles.
- Asynchronous rst at any point returns all registers to reset values immediately. No writes are issued until the next arm.

## Test plan
- ADDR_W=4, deci 1, h_shift 4, rising, level 128, ramp 120,121,… every cycle.
  - Expected writes: 120-123 at addr 0-3, then 124-127 at addr 4-7.
  - 128 at addr 8, so trig_addr=8.
  - 12 post samples fill addr 8-15, 0-3; rd_start_addr=4.
  - wave_ready high one cycle after the addr-3 write.
- deci_rate=3 with continuous valid: ram_wr_en pulses once per 3 valids, storing samples 0,3,6,…. deci_rate=0 gives one write per valid.
- Falling, level 50, data 200×20 then 40.
  - Trigger on the first 40; trig_forced=0.
  - With h_shift 20 > DEPTH-1 (ADDR_W=4), h_lat clamps to 15 and exactly 1 post write occurs.
- AUTO_TIMEOUT=32, constant 100, level 128: the 32nd kept sample in ARMED triggers, trig_forced=1, and the frame completes normally.
- wave_run drop during ARMED: IDLE next cycle, no further writes, wave_ready=0.
- In DONE:
  - With wave_run=0, ram_rd_over is ignored and wave_ready stays 1.
  - With wave_run=1, ram_rd_over gives wave_ready=0 next cycle and new writes start at addr 0.
- rst pulse mid-POST: all outputs 0 immediately; recapture after release produces a correct frame.
